// File: rtl/iir_sos_cascade_tdm.sv
// Cascade of NSEC Direct-Form-I biquad sections sharing one time-multiplexed MAC.
// Samples and coefficients are Q(DW-FRAC).FRAC; each section output is rounded then saturated.
`timescale 1ns/1ps
module iir_sos_cascade_tdm #(
   parameter int DW   = 16,
   parameter int CW   = 16,
   parameter int FRAC = 14,
   parameter int NSEC = 4,
   parameter int ACCW = 40
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DW-1:0]             in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DW-1:0]             out_data,
   input  logic                      coef_we,
   input  logic [$clog2(5*NSEC)-1:0] coef_addr,
   input  logic [CW-1:0]             coef_wdata,
   input  logic                      clr_state,
   output logic                      sat_flag
);
   localparam int NCOEF = 5 * NSEC;
   localparam int AW    = $clog2(NCOEF);
   localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
   localparam int PW    = DW + CW;
   localparam logic [AW-1:0]          NCOEF_L = AW'(NCOEF);
   localparam logic [SW-1:0]          LAST_S  = SW'(NSEC - 1);
   localparam logic signed [ACCW-1:0] HALF    = ACCW'(1) << (FRAC - 1);
   localparam logic signed [ACCW-1:0] YMAX    = (ACCW'(1) << (DW - 1)) - ACCW'(1);
   localparam logic signed [ACCW-1:0] YMIN    = -(ACCW'(1) << (DW - 1));
   localparam logic signed [CW-1:0]   UNITY   = CW'(1) << FRAC;

   typedef enum logic [1:0] {IDLE, MAC, UPD, HOLD} state_t;

   state_t                 state_q, state_d;
   logic signed [CW-1:0]   coef_q [NCOEF];
   logic signed [DW-1:0]   x1_q [NSEC];
   logic signed [DW-1:0]   x2_q [NSEC];
   logic signed [DW-1:0]   y1_q [NSEC];
   logic signed [DW-1:0]   y2_q [NSEC];
   logic signed [DW-1:0]   work_q;
   logic signed [ACCW-1:0] acc_q;
   logic [SW-1:0]          s_q;
   logic [2:0]             t_q;
   logic [AW-1:0]          cidx_q;
   logic                   accept;
   logic signed [CW-1:0]   coef_op;
   logic signed [DW-1:0]   data_op;
   logic signed [PW-1:0]   prod;
   logic signed [ACCW-1:0] prod_ext;
   logic signed [ACCW-1:0] rnd;
   logic signed [ACCW-1:0] r;
   logic                   sat_hi, sat_lo;
   logic signed [DW-1:0]   ysat;

   // A clear request takes the cycle, so no sample may be accepted alongside it.
   assign in_ready = (state_q == IDLE) && !out_valid && !clr_state;

   // cidx_q walks linearly through the coefficient RAM, so it lands on the next section's b0.
   always_comb begin
      coef_op = (cidx_q < NCOEF_L) ? coef_q[cidx_q] : '0;
      case (t_q)
         3'd0:    data_op = work_q;
         3'd1:    data_op = x1_q[s_q];
         3'd2:    data_op = x2_q[s_q];
         3'd3:    data_op = y1_q[s_q];
         default: data_op = y2_q[s_q];
      endcase
   end

   assign prod     = PW'(data_op) * PW'(coef_op);
   assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};
   assign rnd      = acc_q + HALF;
   assign r        = rnd >>> FRAC;
   assign sat_hi   = (r > YMAX);
   assign sat_lo   = (r < YMIN);
   assign ysat     = sat_hi ? {1'b0, {(DW-1){1'b1}}} :
                     sat_lo ? {1'b1, {(DW-1){1'b0}}} : r[DW-1:0];

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               accept  = 1'b1;
               state_d = MAC;
            end
         end
         MAC:     if (t_q == 3'd4) state_d = UPD;
         UPD:     state_d = (s_q == LAST_S) ? HOLD : MAC;
         HOLD:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Feedback taps are subtracted rather than negating a1/a2, so -2^(CW-1) cannot overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCOEF; i++) coef_q[i] <= (i % 5 == 0) ? UNITY : '0;
         for (int i = 0; i < NSEC; i++) begin
            x1_q[i] <= '0;
            x2_q[i] <= '0;
            y1_q[i] <= '0;
            y2_q[i] <= '0;
         end
         work_q    <= '0;
         acc_q     <= '0;
         s_q       <= '0;
         t_q       <= '0;
         cidx_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         sat_flag  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clr_state) begin
                  for (int i = 0; i < NSEC; i++) begin
                     x1_q[i] <= '0;
                     x2_q[i] <= '0;
                     y1_q[i] <= '0;
                     y2_q[i] <= '0;
                  end
                  sat_flag <= 1'b0;
               end
               if (coef_we && (coef_addr < NCOEF_L)) coef_q[coef_addr] <= coef_wdata;
               if (accept) begin
                  work_q <= in_data;
                  acc_q  <= '0;
                  s_q    <= '0;
                  t_q    <= '0;
                  cidx_q <= '0;
               end
            end
            MAC: begin
               acc_q  <= (t_q < 3'd3) ? (acc_q + prod_ext) : (acc_q - prod_ext);
               t_q    <= t_q + 3'd1;
               cidx_q <= cidx_q + AW'(1);
            end
            UPD: begin
               x2_q[s_q] <= x1_q[s_q];
               x1_q[s_q] <= work_q;
               y2_q[s_q] <= y1_q[s_q];
               y1_q[s_q] <= ysat;
               work_q    <= ysat;
               if (sat_hi || sat_lo) sat_flag <= 1'b1;
               if (s_q != LAST_S) begin
                  s_q   <= s_q + SW'(1);
                  t_q   <= '0;
                  acc_q <= '0;
               end else begin
                  out_data  <= ysat;
                  out_valid <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_sos_cascade_tdm.sv
// Self-checking bench for iir_sos_cascade_tdm: directed vector table, corner-case sequences
// and randomized coefficients/samples compared against an arithmetic cascade model.
`timescale 1ns/1ps
module tb_iir_sos_cascade_tdm;
   localparam int DW    = 16;
   localparam int CW    = 16;
   localparam int FRAC  = 14;
   localparam int NSEC  = 4;
   localparam int ACCW  = 40;
   localparam int NCOEF = 5 * NSEC;
   localparam int AW    = $clog2(NCOEF);
   localparam int LAT   = 6 * NSEC;
   localparam int LIMIT = 200;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] in_data, out_data;
   logic          coef_we, clr_state, sat_flag;
   logic [AW-1:0] coef_addr;
   logic [CW-1:0] coef_wdata;

   int checks = 0;
   int errors = 0;

   int cm [NCOEF];
   int mx1 [NSEC];
   int mx2 [NSEC];
   int my1 [NSEC];
   int my2 [NSEC];
   bit satm;

   typedef struct {
      bit load;
      int b0, b1, b2, a1, a2;
      int x;
      int exp_y;
      bit exp_sat;
   } vec_t;

   vec_t vecs [12];

   iir_sos_cascade_tdm #(.DW(DW), .CW(CW), .FRAC(FRAC), .NSEC(NSEC), .ACCW(ACCW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
      .clr_state(clr_state), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
      end
   endtask

   task automatic writeCoef(input int addr, input int val);
      coef_we    = 1'b1;
      coef_addr  = AW'(addr);
      coef_wdata = CW'(val);
      @(posedge clk); #1;
      coef_we    = 1'b0;
   endtask

   task automatic setSection(input int s, input int b0, input int b1, input int b2, input int a1, input int a2);
      writeCoef(5*s+0, b0);
      writeCoef(5*s+1, b1);
      writeCoef(5*s+2, b2);
      writeCoef(5*s+3, a1);
      writeCoef(5*s+4, a2);
   endtask

   task automatic clrState();
      clr_state = 1'b1;
      @(posedge clk); #1;
      clr_state = 1'b0;
   endtask

   task automatic startSample(input int x);
      int guard = 0;
      while (!in_ready && guard < LIMIT) begin
         @(posedge clk); #1;
         guard++;
      end
      in_valid = 1'b1;
      in_data  = DW'(x);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic waitOutput(output int y, output int lat);
      lat = 0;
      while (!out_valid && lat < LIMIT) begin
         @(posedge clk); #1;
         lat++;
      end
      y = int'($signed(out_data));
      if (out_ready) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic applyStimulus(input string name, input int x, output int y);
      int lat;
      startSample(x);
      waitOutput(y, lat);
      checkOutput({name, " latency"}, lat, LAT);
   endtask

   // Reference: each section evaluated straight from its difference equation in wide integers.
   function automatic int modelStep(input int x);
      longint acc, r;
      int v = x;
      for (int s = 0; s < NSEC; s++) begin
         acc = longint'(cm[5*s]) * v + longint'(cm[5*s+1]) * mx1[s] + longint'(cm[5*s+2]) * mx2[s]
             - longint'(cm[5*s+3]) * my1[s] - longint'(cm[5*s+4]) * my2[s];
         r = (acc + (longint'(1) << (FRAC-1))) >>> FRAC;
         if (r > 32767) begin r = 32767; satm = 1'b1; end
         else if (r < -32768) begin r = -32768; satm = 1'b1; end
         mx2[s] = mx1[s]; mx1[s] = v;
         my2[s] = my1[s]; my1[s] = int'(r);
         v = int'(r);
      end
      return v;
   endfunction

   initial begin
      int y, y2, lat, bad, held;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; clr_state = 1'b0;

      vecs[0]  = '{1, 16'h1000, 16'h1000, 16'h1000, 0, 0, 16'h4000, 16'h1000, 0};
      vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 16'h1000, 0};
      vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 16'h1000, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[4]  = '{1, 16'h4000, 0, 0, -8192, 0, 16'h4000, 16'h4000, 0};
      vecs[5]  = '{0, 0, 0, 0, 0, 0, 0, 16'h2000, 0};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 16'h1000, 0};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 16'h0800, 0};
      vecs[8]  = '{1, 16'h2000, 0, 0, 0, 0, 3, 2, 0};
      vecs[9]  = '{0, 0, 0, 0, 0, 0, -3, -1, 0};
      vecs[10] = '{1, 16'h7FFF, 0, 0, 0, 0, 16'h7FFF, 32767, 1};
      vecs[11] = '{0, 0, 0, 0, 0, 0, -32768, -32768, 1};

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      $display("[TB] reset released");
      checkOutput("reset out_valid", out_valid, 0);
      checkOutput("reset out_data", out_data, 0);
      checkOutput("reset sat_flag", sat_flag, 0);
      checkOutput("reset in_ready", in_ready, 1);
      applyStimulus("reset passthrough", 16'h1000, y);
      checkOutput("reset passthrough data", y, 16'h1000);
      checkOutput("reset passthrough sat", sat_flag, 0);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].load) begin
            setSection(0, vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].a1, vecs[i].a2);
            clrState();
         end
         applyStimulus($sformatf("vec%0d", i), vecs[i].x, y);
         checkOutput($sformatf("vec%0d data", i), y, vecs[i].exp_y);
         checkOutput($sformatf("vec%0d sat", i), sat_flag, vecs[i].exp_sat);
      end
      clrState();
      checkOutput("clr_state clears sat_flag", sat_flag, 0);

      // Coefficient write while the MAC is busy must be dropped.
      setSection(0, 16'h4000, 0, 0, 0, 0);
      startSample(16'h1234);
      repeat (2) @(posedge clk);
      #1 writeCoef(0, 0);
      waitOutput(y, lat);
      checkOutput("busy coef_we in-flight", y, 16'h1234);
      applyStimulus("busy coef_we next", 16'h0567, y);
      checkOutput("busy coef_we next data", y, 16'h0567);

      // Backpressure: output held, input refused until the handshake completes.
      out_ready = 1'b0;
      applyStimulus("backpressure", 16'h0ABC, y);
      checkOutput("backpressure data", y, 16'h0ABC);
      in_valid = 1'b1; in_data = 16'h0DEF;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (!out_valid || int'($signed(out_data)) != y || in_ready) bad++;
      end
      checkOutput("backpressure hold cycles bad", bad, 0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("backpressure handshake out_valid", out_valid, 0);
      checkOutput("backpressure in_ready after", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      waitOutput(y2, lat);
      checkOutput("backpressure next latency", lat, LAT);
      checkOutput("backpressure next data", y2, 16'h0DEF);

      // clr_state beats a simultaneous input.
      clr_state = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
      #1 checkOutput("clr priority in_ready", in_ready, 0);
      @(posedge clk); #1;
      clr_state = 1'b0; in_valid = 1'b0;
      held = 0;
      for (int c = 0; c < LAT + 4; c++) begin
         @(posedge clk); #1;
         if (out_valid) held++;
      end
      checkOutput("clr priority no output", held, 0);

      // Randomized coefficients and samples against the model; out-of-range writes ignored.
      for (int rnd = 0; rnd < 2; rnd++) begin
         for (int a = 0; a < NCOEF; a++) begin
            cm[a] = int'($signed(16'($urandom)));
            if (rnd == 0) cm[a] = cm[a] >>> 3;
            writeCoef(a, cm[a]);
         end
         for (int a = NCOEF; a < (1 << AW); a++) writeCoef(a, int'($urandom));
         clrState();
         for (int s = 0; s < NSEC; s++) begin mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0; end
         satm = 1'b0;
         for (int n = 0; n < 10; n++) begin
            int x, ye;
            x = int'($signed(16'($urandom)));
            if (rnd == 0) x = x >>> 1;
            ye = modelStep(x);
            applyStimulus($sformatf("rand%0d_%0d", rnd, n), x, y);
            checkOutput($sformatf("rand%0d_%0d data", rnd, n), y, ye);
            checkOutput($sformatf("rand%0d_%0d sat", rnd, n), sat_flag, satm);
         end
      end

      // Reset mid-MAC: sample dropped, coefficients back to pass-through.
      startSample(16'h3333);
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      checkOutput("abort out_valid", out_valid, 0);
      checkOutput("abort in_ready", in_ready, 1);
      checkOutput("abort sat_flag", sat_flag, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      applyStimulus("abort passthrough", 16'h2345, y);
      checkOutput("abort passthrough data", y, 16'h2345);
      checkOutput("abort passthrough sat", sat_flag, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
